// File: rtl/pixel_tx_pkg.sv
// Shared types and register map for the pixel transmit output block.
// Address constants are 16-bit; the top casts them to ADDR_W.
package pixel_tx_pkg;

  localparam int PIX_W_DEF = 24;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } tx_state_e;

  localparam logic [15:0] CTRL_A      = 16'h0000;
  localparam logic [15:0] FRAME_LEN_A = 16'h0002;
  localparam logic [15:0] STATUS_A    = 16'h0004;
  localparam logic [15:0] TX_COUNT_A  = 16'h0006;

  localparam logic [15:0] FRAME_LEN_RST = 16'd64;

endpackage

// File: rtl/pixel_tx_fifo.sv
// Synchronous pixel FIFO with occupancy count and a flush.
// DEPTH must be a power of two so the pointers wrap naturally.
import pixel_tx_pkg::*;

module pixel_tx_fifo #(
  parameter int PIX_W = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [PIX_W-1:0]         din,
  output logic [PIX_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pixel_tx_out.sv
// Pixel stream transmit end: FIFO, registered output beat, frame/gap FSM.
// Optional PIXEL_TX_PARITY_EN adds the opar output and STATUS bit 8.
import pixel_tx_pkg::*;

module pixel_tx_out #(
  parameter int PIX_W      = 24,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pixel_val_i,
  input  logic              ivalid,
  output logic              iready,
  output logic [PIX_W-1:0]  pixel_val_o,
  output logic              ovalid,
  input  logic              oready,
  output logic              olast,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              rw,
  input  logic              reg_en,
  output logic [DATA_W-1:0] rdata
`ifdef PIXEL_TX_PARITY_EN
  ,
  output logic              opar
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  tx_state_e         state;
  logic              enable;
  logic [DATA_W-1:0] frame_len;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] fl_m1;
  logic [DATA_W-1:0] nxt_idx;
  logic [15:0]       tx_count;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] rd_val;
  logic [PIX_W-1:0]  head;
  logic [LW-1:0]     level;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              ld_last;
  logic              hs;
  logic              wr;
  logic              flush;
  logic              gap_done;
  logic              par_b;
  logic [8:0]        status;

`ifdef PIXEL_TX_PARITY_EN
  assign par_b = 1'b1;
`else
  assign par_b = 1'b0;
`endif

  assign iready   = rst & ~full;
  assign push     = ivalid & iready;
  assign hs       = ovalid & oready;
  assign wr       = reg_en & rw;
  assign flush    = wr && addr == ADDR_W'(CTRL_A) && data[1] && state == IDLE;
  assign fl_m1    = (frame_len == '0) ? '0 : frame_len - DATA_W'(1);
  assign nxt_idx  = hs ? cnt + DATA_W'(1) : cnt;
  assign gap_done = gap_cnt == GW'(GAP_CYCLES - 1);
  assign status   = {par_b, 4'(level), 2'b00, state};

  pixel_tx_fifo #(
    .PIX_W (PIX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (pixel_val_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // The last gap cycle may load directly so the gap is exactly GAP_CYCLES.
  always_comb begin
    pop     = 1'b0;
    ld_last = 1'b0;
    unique case (state)
      STREAM: begin
        pop     = enable && !empty && (!ovalid || (hs && !olast));
        ld_last = nxt_idx >= fl_m1;
      end
      GAP: begin
        pop     = enable && !empty && gap_done;
        ld_last = fl_m1 == '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ovalid      <= 1'b0;
      olast       <= 1'b0;
      pixel_val_o <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      tx_count    <= '0;
`ifdef PIXEL_TX_PARITY_EN
      opar        <= 1'b0;
`endif
    end else begin
      if (hs) tx_count <= tx_count + 16'd1;
      if (pop) begin
        ovalid      <= 1'b1;
        olast       <= ld_last;
        pixel_val_o <= head;
`ifdef PIXEL_TX_PARITY_EN
        opar        <= ^head;
`endif
      end else if (hs) begin
        ovalid <= 1'b0;
        olast  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (flush)  cnt   <= '0;
          if (enable) state <= STREAM;
        end
        STREAM: begin
          if (hs && olast) begin
            cnt     <= '0;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            if (hs) cnt <= cnt + DATA_W'(1);
            if (!enable && (hs || !ovalid)) state <= IDLE;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_done) state <= enable ? STREAM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      addr == ADDR_W'(CTRL_A):      rd_val = DATA_W'(enable);
      addr == ADDR_W'(FRAME_LEN_A): rd_val = frame_len;
      addr == ADDR_W'(STATUS_A):    rd_val = DATA_W'(status);
      addr == ADDR_W'(TX_COUNT_A):  rd_val = DATA_W'(tx_count);
      default:                      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable    <= 1'b0;
      frame_len <= DATA_W'(FRAME_LEN_RST);
      rdata     <= '0;
    end else begin
      if (wr && addr == ADDR_W'(CTRL_A))      enable    <= data[0];
      if (wr && addr == ADDR_W'(FRAME_LEN_A)) frame_len <= data;
      if (reg_en && !rw)                      rdata     <= rd_val;
    end
  end

endmodule

// File: tb/tb_pixel_tx_out.sv
// Directed bench for pixel_tx_out with a beat scoreboard.
// Build with PIXEL_TX_PARITY_EN to also cover opar.
import pixel_tx_pkg::*;

module tb_pixel_tx_out;

  logic        clk = 1'b0;
  logic        rst;
  pixel_t      pixel_val_i;
  logic        ivalid;
  logic        iready;
  pixel_t      pixel_val_o;
  logic        ovalid;
  logic        oready;
  logic        olast;
  logic [15:0] addr;
  logic [15:0] data;
  logic        rw;
  logic        reg_en;
  logic [15:0] rdata;
`ifdef PIXEL_TX_PARITY_EN
  logic        opar;
  localparam logic [15:0] PB = 16'h0100;
`else
  localparam logic [15:0] PB = 16'h0000;
`endif

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int nbeats = 0;
  int nb0;
  logic [15:0] d;
  logic [24:0] sb[$];
  int hs_cyc[$];

  pixel_tx_out dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_val_i (pixel_val_i),
    .ivalid      (ivalid),
    .iready      (iready),
    .pixel_val_o (pixel_val_o),
    .ovalid      (ovalid),
    .oready      (oready),
    .olast       (olast),
    .addr        (addr),
    .data        (data),
    .rw          (rw),
    .reg_en      (reg_en),
    .rdata       (rdata)
`ifdef PIXEL_TX_PARITY_EN
    ,
    .opar        (opar)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst && ovalid && oready) begin
      logic [24:0] e;
      hs_cyc.push_back(cyc);
      nbeats++;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL beat_unexpected obs=%h exp=none", pixel_val_o);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        assert ({pixel_val_o, olast} === e) else begin
          bad++;
          $error("FAIL beat obs=%h/%b exp=%h/%b",
                 pixel_val_o, olast, e[24:1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [15:0] a, input logic [15:0] v);
    addr = a; data = v; rw = 1'b1; reg_en = 1'b1;
    @(posedge clk); #1;
    reg_en = 1'b0; rw = 1'b0;
  endtask

  task automatic reg_rd(input logic [15:0] a, output logic [15:0] v);
    addr = a; rw = 1'b0; reg_en = 1'b1;
    @(posedge clk); #1;
    reg_en = 1'b0;
    v = rdata;
  endtask

  task automatic push(input pixel_t p, input logic ex, input logic lst);
    int n = 0;
    pixel_val_i = p;
    ivalid = 1'b1;
    if (ex) sb.push_back({p, lst});
    @(negedge clk);
    while (!iready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("push_ready", 32'(iready), 32'd1);
    @(posedge clk); #1;
    ivalid = 1'b0;
  endtask

  task automatic wait_ovalid();
    int n = 0;
    @(negedge clk);
    while (!ovalid && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("wait_ovalid", 32'(ovalid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; ivalid = 1'b0; pixel_val_i = '0; oready = 1'b0;
    addr = '0; data = '0; rw = 1'b0; reg_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iready", 32'(iready), 32'd0);
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_olast", 32'(olast), 32'd0);
    chk("rst_pixel", 32'(pixel_val_o), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("iready_after_rst", 32'(iready), 32'd1);
    reg_rd(FRAME_LEN_A, d); chk("fl_reset", 32'(d), 32'd64);
    reg_rd(STATUS_A, d);    chk("status_reset", 32'(d), 32'(PB));
    reg_rd(16'h0010, d);    chk("unmapped", 32'(d), 32'd0);

    // Two frames of four pixels, free-running sink
    oready = 1'b1;
    reg_wr(FRAME_LEN_A, 16'd4);
    reg_wr(CTRL_A, 16'd1);
    hs_cyc.delete();
    for (int i = 1; i <= 8; i++) push(pixel_t'(i), 1'b1, (i % 4) == 0);
    drain();
    chk("gap_len", 32'(hs_cyc[4] - hs_cyc[3]), 32'd3);
    chk("back2back", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
    reg_rd(TX_COUNT_A, d); chk("tx_count", 32'(d), 32'd8);

    // Stall with data held stable, FIFO fills up
    oready = 1'b0;
    push(24'hABCDEF, 1'b1, 1'b0);
    wait_ovalid();
    chk("hold_pix", 32'(pixel_val_o), 32'hABCDEF);
    for (int i = 0; i < 4; i++) begin
      pixel_val_i = 24'h100 + 24'(i);
      ivalid = 1'b1;
      sb.push_back({24'h100 + 24'(i), i == 2});
      @(posedge clk); #1;
      ivalid = 1'b0;
      @(negedge clk);
      chk("hold_pix", 32'(pixel_val_o), 32'hABCDEF);
      chk("hold_vld", 32'(ovalid), 32'd1);
    end
    chk("full_iready", 32'(iready), 32'd0);
    reg_rd(STATUS_A, d); chk("status_full", 32'(d), 32'(16'h0041 | PB));
    oready = 1'b1;
    push(24'h104, 1'b1, 1'b0);
    push(24'h105, 1'b1, 1'b0);
    push(24'h106, 1'b1, 1'b1);
    drain();

    // Disable while beat 2 is stalled, resume with last beat
    reg_wr(FRAME_LEN_A, 16'd3);
    oready = 1'b0;
    push(24'h201, 1'b1, 1'b0);
    push(24'h202, 1'b1, 1'b0);
    wait_ovalid();
    @(posedge clk); #1;
    oready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    oready = 1'b0;
    reg_wr(CTRL_A, 16'd0);
    @(negedge clk);
    chk("dis_stall_vld", 32'(ovalid), 32'd1);
    chk("dis_stall_pix", 32'(pixel_val_o), 32'h202);
    @(posedge clk); #1;
    oready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    push(24'h203, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dis_idle_vld", 32'(ovalid), 32'd0);
    end
    reg_rd(STATUS_A, d); chk("status_idle", 32'(d), 32'(16'h0010 | PB));
    reg_wr(CTRL_A, 16'd1);
    drain();

    // Flush in IDLE drops buffered pixels
    reg_wr(CTRL_A, 16'd0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) push(24'h300 + 24'(i), 1'b0, 1'b0);
    reg_rd(STATUS_A, d); chk("status_pre_flush", 32'(d), 32'(16'h0030 | PB));
    reg_wr(CTRL_A, 16'd2);
    reg_rd(STATUS_A, d); chk("status_flush", 32'(d), 32'(PB));
    reg_rd(CTRL_A, d);   chk("ctrl_flush_rd", 32'(d), 32'd0);
    nb0 = nbeats;
    reg_wr(CTRL_A, 16'd1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("flush_nobeats", 32'(nbeats), 32'(nb0));

    // Flush in STREAM is ignored
    oready = 1'b0;
    push(24'h401, 1'b1, 1'b0);
    push(24'h402, 1'b1, 1'b0);
    wait_ovalid();
    reg_wr(CTRL_A, 16'd3);
    reg_rd(STATUS_A, d); chk("status_noflush", 32'(d), 32'(16'h0011 | PB));
    oready = 1'b1;
    drain();

    // Reset mid-frame
    oready = 1'b0;
    push(24'h501, 1'b1, 1'b1);
    wait_ovalid();
    reg_rd(FRAME_LEN_A, d); chk("fl_before_rst", 32'(d), 32'd3);
    rst = 1'b0;
    #1;
    chk("mid_rst_ovalid", 32'(ovalid), 32'd0);
    chk("mid_rst_olast", 32'(olast), 32'd0);
    chk("mid_rst_pixel", 32'(pixel_val_o), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    reg_rd(FRAME_LEN_A, d); chk("fl_after_rst", 32'(d), 32'd64);

`ifdef PIXEL_TX_PARITY_EN
    reg_wr(CTRL_A, 16'd1);
    push(24'h000007, 1'b1, 1'b0);
    push(24'h000003, 1'b1, 1'b0);
    wait_ovalid();
    chk("opar_7", 32'(opar), 32'd1);
    @(posedge clk); #1;
    oready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    oready = 1'b0;
    @(negedge clk);
    chk("opar_pix", 32'(pixel_val_o), 32'h3);
    chk("opar_3", 32'(opar), 32'd0);
    @(posedge clk); #1;
    oready = 1'b1;
    drain();
`endif
    reg_rd(STATUS_A, d); chk("status_par", 32'(d[8]), 32'(PB[8]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_tx_out.md
Name: pixel_tx_out

Overview:
- Transmit end of the pixel stream. Accepts pixels from the internal datapath on a valid/ready input and buffers them in a small FIFO.
- Drives pixel_val_o/ovalid to the downstream sink, honouring oready. Marks the last pixel of each frame, then inserts an inter-frame gap.
- Configured and observed through the addr/data/rw register port.

Parameters:
- PIX_W, 24, pixel width (RGB 8:8:8)
- DEPTH, 4, FIFO entries; power of 2, minimum 2
- ADDR_W, 16, register address width
- DATA_W, 16, register data width
- GAP_CYCLES, 2, idle cycles forced after each frame's last beat; minimum 1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (active when 0)
- pixel_val_i  in  PIX_W  pixel from internal datapath
- ivalid  in  1  pixel_val_i valid
- iready  out  1  FIFO can accept; equals !full
- pixel_val_o  out  PIX_W  pixel to sink
- ovalid  out  1  pixel_val_o valid
- oready  in  1  sink accepts
- olast  out  1  last pixel of frame, qualified by ovalid
- addr  in  ADDR_W  register address
- data  in  DATA_W  register write data
- rw  in  1  1 = write, 0 = read
- reg_en  in  1  register access strobe, one cycle
- rdata  out  DATA_W  read data, registered, valid the cycle after reg_en && !rw

Behaviour:
- Reset values: iready=0 while rst=0, then 1 because the FIFO is empty. pixel_val_o=0, ovalid=0, olast=0, rdata=0. All registers are 0 except FRAME_LEN=64. FIFO is empty and the state is IDLE.
- Register map:
  - 0x0000 CTRL: bit0 ENABLE; bit1 FLUSH, write-1, self-clearing, reads 0.
  - 0x0002 FRAME_LEN: pixels per frame. 0 is treated as 1.
  - 0x0004 STATUS, RO: [1:0] state, [7:4] FIFO level. Writes are ignored.
  - 0x0006 TX_COUNT, RO: total accepted output beats, wraps at 2^16.
  - Unmapped addresses read 0; writes to them are ignored.
- Input: a push happens when ivalid && iready. A simultaneous push and pop on a full FIFO is not allowed, because iready=0 when full.
- Output stage: ovalid/pixel_val_o/olast are registered (one output register after the FIFO). Latency from push into an empty FIFO to ovalid is 2 cycles.
- Output handshake: a beat completes when ovalid && oready. While ovalid=1 && oready=0, pixel_val_o and olast hold stable. ovalid never drops without a handshake, except on reset or FLUSH.
- States:
  - IDLE (0): ovalid=0. Go to STREAM when ENABLE=1.
  - STREAM (1): load the output register from the FIFO whenever it is empty or completing a beat. The beat counter increments per completed beat. olast=1 when counter == FRAME_LEN-1. A handshake with olast=1 moves to GAP and resets the counter to 0.
  - GAP (2): ovalid=0 for GAP_CYCLES cycles, then go to STREAM if ENABLE, else IDLE.
- ENABLE cleared mid-frame: a beat already presented completes. After that beat's handshake, no new beat is loaded; go to IDLE. The beat counter is kept, so the frame resumes on re-enable.
- FRAME_LEN written mid-frame: the new value is used on the next comparison. If counter >= new FRAME_LEN-1, the next beat carries olast.
- FLUSH: honoured only in IDLE. It empties the FIFO and clears the beat counter the next cycle. In other states it is ignored.
- Reset asserted mid-operation: all state returns to reset values immediately. The in-flight beat is lost.
- TX_COUNT wraps from 0xFFFF to 0x0000 without a flag.

Optional Feature:
- Macro: PIXEL_TX_PARITY_EN.
- Defined: adds output port opar (1 bit) = ^pixel_val_o. It is registered with the beat, obeys the same stability rule as pixel_val_o, and is 0 at reset. STATUS bit 8 reads 1.
- Undefined: the opar port is absent and STATUS bit 8 reads 0.

Decomposition:
- Package pixel_tx_pkg contains:
  - pixel_t typedef;
  - tx_state_e enum (IDLE=0, STREAM=1, GAP=2);
  - register address localparams: CTRL/FRAME_LEN/STATUS/TX_COUNT;
  - FRAME_LEN reset default 64.
- One sub-module, pixel_tx_fifo: synchronous FIFO with push/pop/full/empty/level, parameterised on PIX_W and DEPTH.

Test Plan:
- Reset, then write CTRL=1, FRAME_LEN=4, push 8 pixels 0x000001..0x000008 with oready=1 -> 8 beats in order. olast is set on 0x000004 and 0x000008. ovalid is low for exactly 2 cycles after each olast beat. TX_COUNT reads 8.
- oready=0 for 5 cycles while ovalid=1 with pixel 0xABCDEF -> pixel_val_o holds 0xABCDEF for 5 cycles. Push 4 more pixels during the stall -> iready=0 after the FIFO holds 4 entries.
- FRAME_LEN=3; clear ENABLE after beat 2 while beat 2 is stalled -> beat 2 completes, then ovalid=0. Re-enable -> the next beat has olast=1.
- In IDLE with 3 pixels buffered, write CTRL=0x2 -> STATUS level reads 0 and no beats appear after re-enable. In STREAM, FLUSH has no effect.
- Drop rst (drive to 0) while ovalid=1 mid-frame -> ovalid, olast, pixel_val_o and rdata are 0 immediately. After release, FRAME_LEN reads 64.
- Build with PIXEL_TX_PARITY_EN: pixel 0x000007 -> opar=1, pixel 0x000003 -> opar=0, and STATUS[8]=1. Without the macro, STATUS[8]=0.
